// File: rtl/rgb888_awb.sv
// Gray-world white balance: per-frame R/G/B sums, blanking-time gain divide,
// and a 2-stage saturating gain multiply on the following frame.
module rgb888_awb #(
    parameter int H_SIZE = 640,
    parameter int V_SIZE = 480,
    parameter int ACC_W  = 28,
    parameter int GAIN_W = 12
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic              I_awb_en,
    input  logic              I_rgb_vs,
    input  logic              I_rgb_de,
    input  logic [7:0]        I_rgb_r,
    input  logic [7:0]        I_rgb_g,
    input  logic [7:0]        I_rgb_b,
    output logic              O_awb_vs,
    output logic              O_awb_de,
    output logic [7:0]        O_awb_r,
    output logic [7:0]        O_awb_g,
    output logic [7:0]        O_awb_b,
    output logic [GAIN_W-1:0] O_gain_r,
    output logic [GAIN_W-1:0] O_gain_b,
    output logic              O_awb_busy
);

    localparam int Q_W    = ACC_W + 8;
    localparam int CNT_W  = $clog2(Q_W);
    localparam int PROD_W = 8 + GAIN_W;
    localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(256);

    if (64'(H_SIZE) * 64'(V_SIZE) * 64'd255 >= (64'd1 << ACC_W)) begin : g_acc_chk
        $error("ACC_W too narrow for one full frame of sums");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV_R,
        S_DIV_B,
        S_UPDATE
    } state_t;

    state_t             r_state;
    logic               r_vs_d1;
    logic [ACC_W-1:0]   r_sum_r, r_sum_g, r_sum_b;
    logic [ACC_W-1:0]   r_snap_r, r_snap_g, r_snap_b;
    logic [Q_W-1:0]     r_dvd, r_quo, r_res_r, r_res_b;
    logic [ACC_W-1:0]   r_rem;
    logic [CNT_W-1:0]   r_cnt;
    logic [GAIN_W-1:0]  r_pend_r, r_pend_b;
    logic [GAIN_W-1:0]  r_gain_r, r_gain_b;

    logic               r_vs1, r_de1, r_vs2, r_de2;
    logic [PROD_W-1:0]  r_prod_r, r_prod_b;
    logic [7:0]         r_g1, r_out_r, r_out_g, r_out_b;

    logic               w_rise, w_fall;
    logic [ACC_W-1:0]   w_divisor;
    logic [ACC_W:0]     w_rem_sh;
    logic               w_ge;
    logic [ACC_W:0]     w_rem_sub;
    logic [Q_W-1:0]     w_quo_nxt, w_res;
    logic               w_last;
    logic [GAIN_W-1:0]  w_eff_r, w_eff_b;

    assign w_rise = I_rgb_vs & ~r_vs_d1;
    assign w_fall = ~I_rgb_vs & r_vs_d1;

    function automatic logic [ACC_W-1:0] sat_add(
        input logic [ACC_W-1:0] acc,
        input logic [7:0]       pix
    );
        logic [ACC_W:0] s;
        s = {1'b0, acc} + (ACC_W+1)'(pix);
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    function automatic logic [GAIN_W-1:0] clamp_q(input logic [Q_W-1:0] q);
        return (|q[Q_W-1:GAIN_W]) ? {GAIN_W{1'b1}} : q[GAIN_W-1:0];
    endfunction

    function automatic logic [7:0] sat8(input logic [PROD_W-1:0] p);
        return (|p[PROD_W-1:16]) ? 8'hFF : p[15:8];
    endfunction

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_vs_d1 <= 1'b0;
            r_sum_r <= '0;
            r_sum_g <= '0;
            r_sum_b <= '0;
        end else begin
            r_vs_d1 <= I_rgb_vs;
            if (w_rise) begin
                r_sum_r <= I_rgb_de ? ACC_W'(I_rgb_r) : '0;
                r_sum_g <= I_rgb_de ? ACC_W'(I_rgb_g) : '0;
                r_sum_b <= I_rgb_de ? ACC_W'(I_rgb_b) : '0;
            end else if (I_rgb_vs && I_rgb_de) begin
                r_sum_r <= sat_add(r_sum_r, I_rgb_r);
                r_sum_g <= sat_add(r_sum_g, I_rgb_g);
                r_sum_b <= sat_add(r_sum_b, I_rgb_b);
            end
        end
    end

    // Restoring divide of (Sg << 8) by the selected divisor, MSB first
    assign w_divisor = (r_state == S_DIV_R) ? r_snap_r : r_snap_b;
    assign w_rem_sh  = {r_rem, r_dvd[Q_W-1]};
    assign w_ge      = w_rem_sh >= {1'b0, w_divisor};
    assign w_rem_sub = w_ge ? (w_rem_sh - {1'b0, w_divisor}) : w_rem_sh;
    assign w_quo_nxt = {r_quo[Q_W-2:0], w_ge};
    assign w_last    = (r_cnt == CNT_W'(Q_W-1));
    assign w_res     = (w_divisor == '0) ? Q_W'(256) : w_quo_nxt;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state  <= S_IDLE;
            r_snap_r <= '0;
            r_snap_g <= '0;
            r_snap_b <= '0;
            r_dvd    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_res_r  <= '0;
            r_res_b  <= '0;
            r_pend_r <= UNITY;
            r_pend_b <= UNITY;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_snap_r <= r_sum_r;
                        r_snap_g <= r_sum_g;
                        r_snap_b <= r_sum_b;
                        r_dvd    <= {r_sum_g, 8'h00};
                        r_quo    <= '0;
                        r_rem    <= '0;
                        r_cnt    <= '0;
                        r_state  <= S_DIV_R;
                    end
                end
                S_DIV_R, S_DIV_B: begin
                    r_dvd <= {r_dvd[Q_W-2:0], 1'b0};
                    r_quo <= w_quo_nxt;
                    r_rem <= w_rem_sub[ACC_W-1:0];
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_dvd <= {r_snap_g, 8'h00};
                        r_quo <= '0;
                        r_rem <= '0;
                        r_cnt <= '0;
                        if (r_state == S_DIV_R) begin
                            r_res_r <= w_res;
                            r_state <= S_DIV_B;
                        end else begin
                            r_res_b <= w_res;
                            r_state <= S_UPDATE;
                        end
                    end
                end
                S_UPDATE: begin
                    r_pend_r <= clamp_q(r_res_r);
                    r_pend_b <= clamp_q(r_res_b);
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_gain_r <= UNITY;
            r_gain_b <= UNITY;
        end else if (w_rise) begin
            r_gain_r <= r_pend_r;
            r_gain_b <= r_pend_b;
        end
    end

    assign w_eff_r = I_awb_en ? r_gain_r : UNITY;
    assign w_eff_b = I_awb_en ? r_gain_b : UNITY;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_vs1    <= 1'b0;
            r_de1    <= 1'b0;
            r_prod_r <= '0;
            r_prod_b <= '0;
            r_g1     <= '0;
            r_vs2    <= 1'b0;
            r_de2    <= 1'b0;
            r_out_r  <= '0;
            r_out_g  <= '0;
            r_out_b  <= '0;
        end else begin
            r_vs1    <= I_rgb_vs;
            r_de1    <= I_rgb_de;
            r_prod_r <= PROD_W'(I_rgb_r) * PROD_W'(w_eff_r);
            r_prod_b <= PROD_W'(I_rgb_b) * PROD_W'(w_eff_b);
            r_g1     <= I_rgb_g;
            r_vs2    <= r_vs1;
            r_de2    <= r_de1;
            r_out_r  <= sat8(r_prod_r);
            r_out_g  <= r_g1;
            r_out_b  <= sat8(r_prod_b);
        end
    end

    assign O_awb_vs   = r_vs2;
    assign O_awb_de   = r_de2;
    assign O_awb_r    = r_out_r;
    assign O_awb_g    = r_out_g;
    assign O_awb_b    = r_out_b;
    assign O_gain_r   = r_gain_r;
    assign O_gain_b   = r_gain_b;
    assign O_awb_busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_rgb888_awb.sv
// Directed bench for rgb888_awb: gain derivation, apply path,
// busy window, busy-time fall rejection and mid-divide reset.
module tb_rgb888_awb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        awb_en = 1'b1;
    logic        vs = 1'b0;
    logic        de = 1'b0;
    logic [7:0]  pr = '0, pg = '0, pb = '0;
    logic        o_vs, o_de;
    logic [7:0]  o_r, o_g, o_b;
    logic [11:0] o_gr, o_gb;
    logic        o_busy;

    int n_vec = 0;
    int n_err = 0;
    int bcnt;

    always #5 clk = ~clk;

    rgb888_awb dut (
        .I_clk     (clk),
        .I_rst_n   (rst_n),
        .I_awb_en  (awb_en),
        .I_rgb_vs  (vs),
        .I_rgb_de  (de),
        .I_rgb_r   (pr),
        .I_rgb_g   (pg),
        .I_rgb_b   (pb),
        .O_awb_vs  (o_vs),
        .O_awb_de  (o_de),
        .O_awb_r   (o_r),
        .O_awb_g   (o_g),
        .O_awb_b   (o_b),
        .O_gain_r  (o_gr),
        .O_gain_b  (o_gb),
        .O_awb_busy(o_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        vs = 1'b1;
        de = 1'b0;
        tick();
        tick();
    endtask

    task automatic pix(input logic [7:0] r, g, b,
                       input logic [7:0] er, eg, eb);
        pr = r; pg = g; pb = b;
        de = 1'b1;
        tick();
        de = 1'b0;
        tick();
        chk("out_de", 32'(o_de), 32'd1);
        chk("out_r", 32'(o_r), 32'(er));
        chk("out_g", 32'(o_g), 32'(eg));
        chk("out_b", 32'(o_b), 32'(eb));
    endtask

    task automatic end_frame(input int cycles, output int busy_cycles);
        vs = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (o_busy) busy_cycles++;
        end
    endtask

    task automatic gains(input string tag, input logic [11:0] gr, gb);
        chk({tag, "_gr"}, 32'(o_gr), 32'(gr));
        chk({tag, "_gb"}, 32'(o_gb), 32'(gb));
    endtask

    initial begin
        tick();
        tick();
        chk("rst_r", 32'(o_r), 32'd0);
        chk("rst_vs", 32'(o_vs), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        gains("rst", 12'h100, 12'h100);
        rst_n = 1'b1;
        tick();

        // F1: flat grey, unity gains
        start_frame();
        for (int i = 0; i < 16; i++) pix(100, 100, 100, 100, 100, 100);
        end_frame(90, bcnt);
        chk("f1_busy", 32'(bcnt), 32'd73);

        // F2: grey result gives unity; stats 1024/2048/512
        start_frame();
        gains("f2", 12'h100, 12'h100);
        for (int i = 0; i < 16; i++) pix(64, 128, 32, 64, 128, 32);
        end_frame(90, bcnt);
        chk("f2_busy", 32'(bcnt), 32'd73);

        // F3: gains 2.0/4.0 with saturation, then bypass
        start_frame();
        gains("f3", 12'h200, 12'h400);
        for (int i = 0; i < 8; i++) pix(64, 128, 32, 128, 128, 128);
        for (int i = 0; i < 4; i++) pix(200, 100, 80, 255, 100, 255);
        awb_en = 1'b0;
        for (int i = 0; i < 4; i++) pix(200, 100, 80, 200, 100, 80);
        end_frame(90, bcnt);
        chk("f3_busy", 32'(bcnt), 32'd73);

        // F4: bypass; gains from F3 sums 2112/1824/896 -> 221/521
        start_frame();
        gains("f4", 12'd221, 12'd521);
        for (int i = 0; i < 16; i++) pix(0, 50, 1, 0, 50, 1);
        end_frame(90, bcnt);
        chk("f4_busy", 32'(bcnt), 32'd73);

        // F5: zero red divisor -> unity, blue 12800 clamps to 0xFFF
        awb_en = 1'b1;
        start_frame();
        gains("f5", 12'h100, 12'hFFF);
        for (int i = 0; i < 16; i++) pix(128, 64, 32, 128, 64, 255);
        // short frame whose fall lands while the divider is busy
        vs = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        vs = 1'b1;
        tick();
        tick();
        pr = 64; pg = 128; pb = 32;
        de = 1'b1;
        tick();
        de = 1'b0;
        tick();
        tick();
        tick();
        chk("f5b_busy_at_fall", 32'(o_busy), 32'd1);
        end_frame(100, bcnt);
        chk("f5b_busy_rest", 32'(bcnt), 32'd63);

        // F6: gains from F5 only -> 0x080/0x200
        start_frame();
        gains("f6", 12'h080, 12'h200);
        for (int i = 0; i < 16; i++) pix(64, 128, 32, 32, 128, 64);
        end_frame(50, bcnt);
        chk("f6_busy_pre", 32'(o_busy), 32'd1);
        chk("f6_pre_r", 32'(o_r), 32'd32);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_r", 32'(o_r), 32'd0);
        chk("mrst_g", 32'(o_g), 32'd0);
        chk("mrst_b", 32'(o_b), 32'd0);
        chk("mrst_busy", 32'(o_busy), 32'd0);
        gains("mrst", 12'h100, 12'h100);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // F7: normal operation after reset
        start_frame();
        gains("f7", 12'h100, 12'h100);
        for (int i = 0; i < 16; i++) pix(64, 128, 32, 64, 128, 32);
        end_frame(90, bcnt);
        chk("f7_busy", 32'(bcnt), 32'd73);

        start_frame();
        gains("f8", 12'h200, 12'h400);
        end_frame(5, bcnt);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
